seq_div_u8_by_u4: RTL and testbench

//  Iterative unsigned restoring divider; inverse of the combinational 4x4->8 multiplier block.

---
 rtl/seq_div_u8_by_u4_if.sv | 26 ++
 rtl/seq_div_u8_by_u4.sv | 104 ++++++++++
 tb/tb_seq_div_u8_by_u4.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seq_div_u8_by_u4_if.sv
// Operand/result handshake bundle for the iterative u8/u4 divider.
// The master side supplies operands and accepts results; the slave side is the divider.
interface seq_div_u8_by_u4_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/seq_div_u8_by_u4.sv
// Iterative unsigned restoring divider: DW-bit dividend by VW-bit divisor,
// one quotient bit per cycle. Used to check multiplier product/operand pairs.
module seq_div_u8_by_u4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_div_u8_by_u4_if.slave  bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [VW-1:0] p_q;        // partial remainder
    logic [DW-1:0] q_q;        // dividend bits shift out the top, quotient bits in at the bottom
    logic [VW-1:0] dvs_q;
    logic [DW-1:0] quo_q;
    logic [VW-1:0] rem_q;
    logic          dz_q;
    logic          in_ready_q;
    logic          out_valid_q;

    logic [VW:0]   shifted;
    logic          ge;
    logic [VW-1:0] sub;
    logic [VW-1:0] p_d;
    logic [DW-1:0] q_d;

    // One restoring step. The shifted remainder needs VW+1 bits for the compare, but
    // whenever the subtraction is taken with divisor != 0 the result is < divisor, so
    // VW-bit modular subtraction is exact. With divisor == 0 the compare always passes
    // and only the low VW bits (the last dividend bits) survive, which is the defined
    // divide-by-zero remainder.
    always_comb begin
        shifted = {p_q, q_q[DW-1]};
        ge      = (shifted >= {1'b0, dvs_q});
        sub     = shifted[VW-1:0] - dvs_q;
        p_d     = ge ? sub : shifted[VW-1:0];
        q_d     = {q_q[DW-2:0], ge};
    end

    // Control FSM with registered handshake and result outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        q_q        <= bus.dividend;
                        dvs_q      <= bus.divisor;
                        p_q        <= '0;
                        cnt_q      <= CW'(DW - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    p_q <= p_d;
                    q_q <= q_d;
                    if (cnt_q == '0) begin
                        quo_q       <= q_d;
                        rem_q       <= p_d;
                        dz_q        <= (dvs_q == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_seq_div_u8_by_u4.sv
// Directed bench for the iterative u8/u4 divider: reset, latency, extremes,
// divide-by-zero, backpressure, mid-operation reset and an exhaustive sweep.
module tb_seq_div_u8_by_u4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    seq_div_u8_by_u4_if #(.DW(8), .VW(4)) bus ();

    seq_div_u8_by_u4 #(.DW(8), .VW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready (bounded), present operands for exactly the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [3:0] d);
        int n = 0;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("in_ready_timeout", 32'd0, 32'd1);
        bus.dividend = a;
        bus.divisor  = d;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Count samples from the accepting edge (inclusive) until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    function automatic logic [7:0] mul4(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) acc = acc + (8'(a) << i);
        return acc;
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [3:0] d;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        int hits;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;

        // Directed vectors: T1, T2 extremes, T3 divide-by-zero
        vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
        vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};
        vecs[2] = '{8'd5,   4'd15, 8'd0,   4'd5, 1'b0};
        vecs[3] = '{8'd0,   4'd9,  8'd0,   4'd0, 1'b0};
        vecs[4] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
        vecs[5] = '{8'hA5,  4'd0,  8'hFF,  4'h5, 1'b1};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", {19'd0, bus.quotient, bus.remainder, bus.div_zero}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].a, vecs[i].d);
            wait_out(lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd9);
            chk($sformatf("vec%0d_q", i), 32'(bus.quotient), 32'(vecs[i].q));
            chk($sformatf("vec%0d_r", i), 32'(bus.remainder), 32'(vecs[i].r));
            chk($sformatf("vec%0d_z", i), 32'(bus.div_zero), 32'(vecs[i].z));
        end

        // T4 backpressure: 123/10 = 12 r 3, held for 20 cycles while in_valid is ignored
        tick();
        bus.out_ready = 1'b0;
        issue(8'd123, 4'd10);
        wait_out(lat);
        chk("bp_lat", 32'(lat), 32'd9);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.dividend = 8'd100;
            bus.divisor  = 4'd3;
            tick();
            chk("bp_hold", {18'd0, bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_zero},
                {18'd0, 1'b0, 1'b1, 8'd12, 4'd3, 1'b0});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

        // Ignored operands must not have started an operation; next op is its own: 77/6 = 12 r 5
        issue(8'd77, 4'd6);
        wait_out(lat);
        chk("post_bp_lat", 32'(lat), 32'd9);
        chk("post_bp_result", {19'd0, bus.quotient, bus.remainder, bus.div_zero}, {19'd0, 8'd12, 4'd5, 1'b0});

        // T5 reset during CALC cycle 4
        issue(8'd250, 4'd3);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_result", {19'd0, bus.quotient, bus.remainder, bus.div_zero}, 32'd0);
        hits = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.out_valid) hits++;
        end
        chk("midrst_no_stale", 32'(hits), 32'd0);

        // T6 exhaustive sweep with out_ready held high
        for (int a = 0; a < 256; a++) begin
            for (int d = 0; d < 16; d++) begin
                logic [7:0] eq;
                logic [3:0] er;
                logic       ok;
                int         prod;
                if (d == 0) begin
                    eq = 8'hFF;
                    er = 4'(a);
                end else begin
                    eq = 8'(a / d);
                    er = 4'(a % d);
                end
                issue(8'(a), 4'(d));
                wait_out(lat);
                chk($sformatf("exh_%0d_%0d", a, d),
                    {18'd0, bus.out_valid, bus.quotient, bus.remainder, bus.div_zero},
                    {18'd0, 1'b1, eq, er, (d == 0)});
                if (d != 0) begin
                    prod = int'(bus.quotient) * d;
                    ok = (prod + int'(bus.remainder) == a) && (int'(bus.remainder) < d);
                    if (bus.quotient < 8'd16)
                        ok = ok && (int'(mul4(bus.quotient[3:0], 4'(d))) == prod);
                    chk($sformatf("inv_%0d_%0d", a, d), 32'(ok), 32'd1);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
